pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
- Parametrised successor to the fixed four-latch MIPS pipeline plumbing.
- Holds NUM_STAGES uniform-width stage registers, each with a valid bit and a halt-marker bit.
- Applies per-stage stall (bubble insertion) and per-stage flush.
- Gates advancement through a debugger-controlled run/step/halt state machine with cycle and retire counters.
- Sits between the fetch front-end and the stage datapaths; the debugger reads snapshots from its outputs.

Parameters:
- NUM_STAGES, 4, number of pipeline stage registers (≥2).
- DATA_W, 129, width of each stage payload (widest inter-stage bus).
- CNT_W, 32, width of cycle and retire counters.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_run  in  1  start pulse; honoured in IDLE and HALTED.
- i_mode  in  1  0 = continuous run, 1 = single-step.
- i_step  in  1  step pulse; one advance per cycle asserted while in STEP.
- i_stall_req  in  NUM_STAGES  bit k: stage k must hold this cycle.
- i_flush  in  NUM_STAGES  bit k: invalidate stage k this cycle.
- i_in_data  in  DATA_W  payload entering stage 0.
- i_in_valid  in  1  i_in_data is valid.
- i_in_halt  in  1  entering payload is a halt marker.
- o_in_ready  out  1  stage 0 accepts i_in_data this cycle.
- o_stage_data  out  NUM_STAGES*DATA_W  stage k at [k*DATA_W +: DATA_W].
- o_stage_valid  out  NUM_STAGES  per-stage valid.
- o_adv  out  1  global advance enable this cycle.
- o_state  out  2  00 IDLE, 01 RUN, 10 STEP, 11 HALTED.
- o_cycle_cnt  out  CNT_W  advance cycles since last start.
- o_retire_cnt  out  CNT_W  valid entries retired from last stage.
- o_halted  out  1  high iff state is HALTED.

Behaviour:
- **Reset (i_rst=1 at edge):**
  - All stage data, valid and halt bits clear to 0; state IDLE; counters 0.
  - o_in_ready=0, o_adv=0, o_halted=0.
  - Reset mid-run discards all in-flight entries.
- **o_adv (combinational):** (state==RUN) | (state==STEP & i_step).
- **hold[s]:** OR of i_stall_req[k] for k=s..NUM_STAGES-1. A stall at stage k freezes stages 0..k.
- **draining:** OR over s of (valid[s] & halt[s]).
- **o_in_ready:** o_adv & ~hold[0] & ~draining.
- **Stage update, per stage s, per edge, priority order:**
  1. i_flush[s] → valid=0, halt=0, data=0. Flush applies even when o_adv=0.
  2. else ~o_adv or hold[s] → keep.
  3. else s==0 → load {i_in_data, i_in_valid&o_in_ready, i_in_halt&i_in_valid&o_in_ready}.
  4. else hold[s-1] → bubble (valid=0, halt=0, data=0).
  5. else copy stage s-1.
- **Retire:** the last stage's content leaves when o_adv & ~hold[N-1] & ~i_flush[N-1].
  - If that content is valid, o_retire_cnt += 1.
  - If it is also halt-marked, state→HALTED next cycle.
- **o_cycle_cnt:** += 1 on every o_adv cycle.
- **Counters:** both saturate at all-ones; both clear on an accepted i_run.
- **FSM:**
  - IDLE: i_run → RUN if i_mode=0, else STEP.
  - RUN: i_mode=1 → STEP.
  - STEP: i_mode=0 → RUN.
  - RUN/STEP: halt retire → HALTED. This takes priority over a mode change.
  - HALTED: i_run → RUN/STEP per i_mode; stage registers are kept as-is (already drained).
  - i_run in RUN/STEP is ignored.
  - i_step outside STEP is ignored.
- **Halt-marker flush:** flushing a halt-marked entry cancels draining; fetch resumes the next advance cycle.
- **Simultaneous i_flush[s] and i_stall_req[s]:** flush wins.
- **Timing:** no combinational path from i_step/i_run to the stage registers other than through o_adv; latency is one cycle per stage.

Test Plan:
1. **Basic run:** reset, i_mode=0, i_run; feed payloads 1..6 with valid every cycle, no stalls, N=4.
   → payload 1 visible in stage 3 on the 4th edge after acceptance; after 10 advance cycles o_retire_cnt=6.
2. **Stall bubble:** in RUN, i_stall_req=4'b0010 for 2 cycles with stages holding A,B,C,D.
   → stages 0–1 frozen; stage 2 holds bubbles (valid=0) for 2 cycles; o_in_ready=0 during the stall.
3. **Flush:** i_flush=4'b0001 together with i_stall_req[0]=1.
   → stage 0 valid=0 next cycle (flush wins); the other stages continue.
4. **Single-step:** i_mode=1, i_run, then 3 i_step pulses spaced 5 cycles apart.
   → o_cycle_cnt=3; the pipeline moves exactly 3 positions; o_adv high only on the pulse cycles.
5. **Halt drain:** send 0x11, 0x22, then halt-marked 0x33, then 0x44 offered.
   → 0x44 never accepted (o_in_ready=0); HALTED one cycle after 0x33 retires; o_retire_cnt=3; o_halted=1.
6. **Restart and reset:**
   - i_run from HALTED → counters read 0 and state is RUN.
   - i_rst asserted mid-run with 3 valid stages → all valid bits 0, state IDLE on the next edge.

Source files
------------

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_sequencer
//  Description : Parametrised pipeline stage-register sequencer. Holds
//                NUM_STAGES payload registers with valid and halt-marker
//                bits. It applies per-stage stall (bubble insertion) and
//                per-stage flush. A run/step/halt state machine gates all
//                advancement and is controlled by the debugger. The block
//                also keeps advance-cycle and retire counters.
//
//  Ports       : i_clk, i_rst       clock, synchronous active-high reset
//                i_run, i_mode      start pulse, 0=continuous 1=single-step
//                i_step             single-step advance pulse
//                i_stall_req        per-stage hold request
//                i_flush            per-stage invalidate
//                i_in_data/valid/halt, o_in_ready   stage-0 input handshake
//                o_stage_data       stage k at [k*DATA_W +: DATA_W]
//                o_stage_valid      per-stage valid
//                o_adv              global advance enable
//                o_state            00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//                o_cycle_cnt        advance cycles since last start
//                o_retire_cnt       valid entries retired since last start
//                o_halted           state is HALTED
//
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int DATA_W     = 129,
    parameter int CNT_W      = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_run,
    input  logic                         i_mode,
    input  logic                         i_step,
    input  logic [NUM_STAGES-1:0]        i_stall_req,
    input  logic [NUM_STAGES-1:0]        i_flush,
    input  logic [DATA_W-1:0]            i_in_data,
    input  logic                         i_in_valid,
    input  logic                         i_in_halt,
    output logic                         o_in_ready,
    output logic [NUM_STAGES*DATA_W-1:0] o_stage_data,
    output logic [NUM_STAGES-1:0]        o_stage_valid,
    output logic                         o_adv,
    output logic [1:0]                   o_state,
    output logic [CNT_W-1:0]             o_cycle_cnt,
    output logic [CNT_W-1:0]             o_retire_cnt,
    output logic                         o_halted
);

    localparam logic [1:0] c_st_idle   = 2'b00;
    localparam logic [1:0] c_st_run    = 2'b01;
    localparam logic [1:0] c_st_step   = 2'b10;
    localparam logic [1:0] c_st_halted = 2'b11;

    logic [DATA_W-1:0]     r_data [NUM_STAGES];
    logic [NUM_STAGES-1:0] r_valid;
    logic [NUM_STAGES-1:0] r_halt;
    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cycle_cnt;
    logic [CNT_W-1:0]      r_retire_cnt;

    logic [DATA_W-1:0]     w_nxt_data [NUM_STAGES];
    logic [NUM_STAGES-1:0] w_nxt_valid;
    logic [NUM_STAGES-1:0] w_nxt_halt;
    logic [NUM_STAGES-1:0] w_hold;
    logic [1:0]            w_nxt_state;
    logic                  w_adv;
    logic                  w_draining;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_retire;
    logic                  w_retire_valid;
    logic                  w_retire_halt;
    logic                  w_start;

    // A stall at stage k freezes every stage upstream of it, so the hold for
    // stage s is the OR of all stall requests from s to the end.
    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_hold
        assign w_hold[s] = |i_stall_req[NUM_STAGES-1:s];
    end

    assign w_adv = (r_state == c_st_run) || ((r_state == c_st_step) && i_step);

    // Once a halt marker is anywhere in the pipe, fetch stops so that the
    // marker can drain out cleanly. Flushing the marker cancels the drain.
    assign w_draining = |(r_valid & r_halt);
    assign w_in_ready = w_adv && !w_hold[0] && !w_draining;
    assign w_accept   = i_in_valid && w_in_ready;

    assign w_retire       = w_adv && !w_hold[NUM_STAGES-1] && !i_flush[NUM_STAGES-1];
    assign w_retire_valid = w_retire && r_valid[NUM_STAGES-1];
    assign w_retire_halt  = w_retire_valid && r_halt[NUM_STAGES-1];

    assign w_start = i_run && ((r_state == c_st_idle) || (r_state == c_st_halted));

    // Next stage contents. Priority: flush, keep, load/bubble/copy.
    always_comb begin
        for (int s = 0; s < NUM_STAGES; s++) begin
            w_nxt_data[s]  = r_data[s];
            w_nxt_valid[s] = r_valid[s];
            w_nxt_halt[s]  = r_halt[s];
        end

        if (i_flush[0]) begin
            w_nxt_data[0]  = '0;
            w_nxt_valid[0] = 1'b0;
            w_nxt_halt[0]  = 1'b0;
        end else if (w_adv && !w_hold[0]) begin
            w_nxt_data[0]  = i_in_data;
            w_nxt_valid[0] = w_accept;
            w_nxt_halt[0]  = w_accept && i_in_halt;
        end

        for (int s = 1; s < NUM_STAGES; s++) begin
            if (i_flush[s]) begin
                w_nxt_data[s]  = '0;
                w_nxt_valid[s] = 1'b0;
                w_nxt_halt[s]  = 1'b0;
            end else if (w_adv && !w_hold[s]) begin
                if (w_hold[s-1]) begin
                    // Upstream is frozen: insert a bubble behind the stall.
                    w_nxt_data[s]  = '0;
                    w_nxt_valid[s] = 1'b0;
                    w_nxt_halt[s]  = 1'b0;
                end else begin
                    w_nxt_data[s]  = r_data[s-1];
                    w_nxt_valid[s] = r_valid[s-1];
                    w_nxt_halt[s]  = r_halt[s-1];
                end
            end
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            c_st_idle, c_st_halted: begin
                if (i_run) begin
                    w_nxt_state = i_mode ? c_st_step : c_st_run;
                end
            end
            c_st_run: begin
                if (w_retire_halt) begin
                    w_nxt_state = c_st_halted;
                end else if (i_mode) begin
                    w_nxt_state = c_st_step;
                end
            end
            default: begin
                if (w_retire_halt) begin
                    w_nxt_state = c_st_halted;
                end else if (!i_mode) begin
                    w_nxt_state = c_st_run;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                r_data[s] <= '0;
            end
            r_valid <= '0;
            r_halt  <= '0;
            r_state <= c_st_idle;
        end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                r_data[s] <= w_nxt_data[s];
            end
            r_valid <= w_nxt_valid;
            r_halt  <= w_nxt_halt;
            r_state <= w_nxt_state;
        end
    end

    // A start is only accepted in IDLE/HALTED, where o_adv is low, so
    // clearing and counting can never collide.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_start) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_adv && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (w_retire_valid && (r_retire_cnt != '1)) begin
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_out
        assign o_stage_data[s*DATA_W +: DATA_W] = r_data[s];
    end

    assign o_stage_valid = r_valid;
    assign o_in_ready    = w_in_ready;
    assign o_adv         = w_adv;
    assign o_state       = r_state;
    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_retire_cnt  = r_retire_cnt;
    assign o_halted      = (r_state == c_st_halted);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_sequencer
//  Description : Self-checking bench for pipeline_sequencer (N=4). Accepted
//                payloads are queued and compared in order as they retire
//                from the last stage; directed checks cover stall, flush,
//                single-step, halt drain, restart and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_sequencer;

    localparam int NUM_STAGES = 4;
    localparam int DATA_W     = 129;
    localparam int CNT_W      = 32;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         run, mode, step;
    logic [NUM_STAGES-1:0]        stall, flush;
    logic [DATA_W-1:0]            in_data;
    logic                         in_valid, in_halt;
    logic                         o_in_ready;
    logic [NUM_STAGES*DATA_W-1:0] o_stage_data;
    logic [NUM_STAGES-1:0]        o_stage_valid;
    logic                         o_adv;
    logic [1:0]                   o_state;
    logic [CNT_W-1:0]             o_cycle_cnt;
    logic [CNT_W-1:0]             o_retire_cnt;
    logic                         o_halted;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] exp_d;

    pipeline_sequencer #(
        .NUM_STAGES (NUM_STAGES),
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_run         (run),
        .i_mode        (mode),
        .i_step        (step),
        .i_stall_req   (stall),
        .i_flush       (flush),
        .i_in_data     (in_data),
        .i_in_valid    (in_valid),
        .i_in_halt     (in_halt),
        .o_in_ready    (o_in_ready),
        .o_stage_data  (o_stage_data),
        .o_stage_valid (o_stage_valid),
        .o_adv         (o_adv),
        .o_state       (o_state),
        .o_cycle_cnt   (o_cycle_cnt),
        .o_retire_cnt  (o_retire_cnt),
        .o_halted      (o_halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Payload pattern exercising the top, middle and bottom bits.
    function automatic logic [DATA_W-1:0] mk(input logic [7:0] v);
        return {1'b1, 120'(v) << 4, v};
    endfunction

    function automatic logic [DATA_W-1:0] stg(input int k);
        return o_stage_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: push on accept, pop and compare on retire from stage 3.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (o_adv && !stall[NUM_STAGES-1] && !flush[NUM_STAGES-1] &&
                o_stage_valid[NUM_STAGES-1]) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_d = sb.pop_front();
                    check("retire_data", stg(NUM_STAGES-1), exp_d);
                end
            end
            if (o_in_ready && in_valid) sb.push_back(in_data);
        end
    end

    initial begin
        int n;
        rst = 1'b1; run = 0; mode = 0; step = 0; stall = '0; flush = '0;
        in_data = '0; in_valid = 0; in_halt = 0;
        do_reset();

        // Reset state
        check("rst_state",  o_state, 2'b00);
        check("rst_valid",  o_stage_valid, 4'b0000);
        check("rst_ready",  o_in_ready, 0);
        check("rst_adv",    o_adv, 0);
        check("rst_cycle",  o_cycle_cnt, 0);
        check("rst_retire", o_retire_cnt, 0);
        check("rst_halted", o_halted, 0);
        check("rst_data3",  stg(3), 0);

        // Basic run: payloads 1..6
        mode = 0; run = 1; tick(); run = 0;
        check("run_state", o_state, 2'b01);
        for (int i = 1; i <= 6; i++) begin
            in_data = mk(8'(i)); in_valid = 1;
            @(negedge clk);
            check("run_ready", o_in_ready, 1);
            tick();
            if (i == 4) check("run_lat_s3", stg(3), mk(8'd1));
        end
        in_valid = 0;
        repeat (4) tick();
        check("run_cycle",  o_cycle_cnt, 10);
        check("run_retire", o_retire_cnt, 6);
        check("run_sb_empty", sb.size(), 0);

        // Stall bubble: stall stage 1 for two cycles
        for (int v = 8'hA; v <= 8'hD; v++) begin
            in_data = mk(8'(v)); in_valid = 1; tick();
        end
        in_data = mk(8'hE);
        stall = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("stall_ready", o_in_ready, 0);
            tick();
            check("stall_s0", stg(0), mk(8'hD));
            check("stall_s1", stg(1), mk(8'hC));
            check("stall_bubble", o_stage_valid[2], 0);
        end
        stall = '0;
        tick();
        in_valid = 0;
        repeat (6) tick();
        check("stall_sb_empty", sb.size(), 0);

        // Flush wins over stall at stage 0
        in_data = mk(8'h21); in_valid = 1; tick();
        in_data = mk(8'h22); tick();
        in_valid = 0;
        flush = 4'b0001; stall = 4'b0001;
        void'(sb.pop_back());
        tick();
        flush = '0; stall = '0;
        check("flush_v0", o_stage_valid[0], 0);
        check("flush_s2", stg(2), mk(8'h21));
        check("flush_v2", o_stage_valid[2], 1);
        repeat (4) tick();
        check("flush_sb_empty", sb.size(), 0);

        // Single-step
        do_reset();
        mode = 1; run = 1; tick(); run = 0;
        check("step_state", o_state, 2'b10);
        in_valid = 1;
        for (int k = 1; k <= 3; k++) begin
            in_data = mk(8'(8'h50 + k));
            step = 1;
            @(negedge clk);
            check("step_adv", o_adv, 1);
            tick();
            step = 0;
            repeat (4) begin
                @(negedge clk);
                check("gap_adv", o_adv, 0);
                tick();
            end
        end
        in_valid = 0;
        check("step_cycle", o_cycle_cnt, 3);
        check("step_valid", o_stage_valid, 4'b0111);
        check("step_s2", stg(2), mk(8'h51));
        check("step_s0", stg(0), mk(8'h53));

        // Halt drain
        do_reset();
        mode = 0; run = 1; tick(); run = 0;
        in_valid = 1;
        in_data = mk(8'h11); tick();
        in_data = mk(8'h22); tick();
        in_data = mk(8'h33); in_halt = 1; tick();
        in_data = mk(8'h44); in_halt = 0;
        n = 0;
        while (!o_halted && n < 20) begin
            @(negedge clk);
            check("drain_ready", o_in_ready, 0);
            tick();
            n++;
        end
        check("halt_latency", n, 4);
        check("halt_flag",   o_halted, 1);
        check("halt_state",  o_state, 2'b11);
        check("halt_retire", o_retire_cnt, 3);
        check("halt_cycle",  o_cycle_cnt, 7);
        check("halt_valid",  o_stage_valid, 4'b0000);
        check("halt_sb_empty", sb.size(), 0);

        // Restart from HALTED, then reset mid-run
        in_valid = 0;
        run = 1; tick(); run = 0;
        check("restart_state",  o_state, 2'b01);
        check("restart_cycle",  o_cycle_cnt, 0);
        check("restart_retire", o_retire_cnt, 0);
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = mk(8'(8'h61 + i)); tick();
        end
        in_valid = 0;
        check("pre_rst_valid", o_stage_valid, 4'b0111);
        rst = 1; tick(); rst = 0;
        check("midrst_valid", o_stage_valid, 4'b0000);
        check("midrst_state", o_state, 2'b00);
        check("midrst_cycle", o_cycle_cnt, 0);
        check("midrst_adv",   o_adv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
